// File: rtl/lc3_decode_pkg.sv
// LC-3 decode stage shared definitions.
// Opcodes, control encodings, NOP word and decoded control bundle.
package lc3_decode_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] W_ALU = 2'b00;
    localparam logic [1:0] W_MEM = 2'b01;
    localparam logic [1:0] W_PC  = 2'b10;

    localparam logic [1:0] PCS1_OFF11 = 2'b00;
    localparam logic [1:0] PCS1_OFF9  = 2'b01;
    localparam logic [1:0] PCS1_OFF6  = 2'b10;
    localparam logic [1:0] PCS1_ZERO  = 2'b11;

    localparam logic PCS2_NPC  = 1'b1;
    localparam logic PCS2_VSR1 = 1'b0;

    // BR with nzp=000: never taken.
    localparam logic [15:0] DEF_NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [1:0] alu;
        logic [1:0] pcsel1;
        logic       pcsel2;
        logic       op2sel;
    } e_ctl_t;

    typedef struct packed {
        e_ctl_t     e;
        logic [1:0] w;
        logic       mem;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/lc3_decode_ctl.sv
// LC-3 opcode to control-bundle decoder.
// Purely combinational; unlisted opcodes decode as illegal.
module lc3_decode_ctl
    import lc3_decode_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       imm_flag,
    output dec_t       dec
);

    // Opcode lookup; every field defaults to zero.
    always_comb begin
        dec = '0;
        unique case (opcode)
            OP_ADD: begin
                dec.e.alu    = ALU_ADD;
                dec.e.op2sel = ~imm_flag;
                dec.w        = W_ALU;
                dec.legal    = 1'b1;
            end
            OP_AND: begin
                dec.e.alu    = ALU_AND;
                dec.e.op2sel = ~imm_flag;
                dec.w        = W_ALU;
                dec.legal    = 1'b1;
            end
            OP_NOT: begin
                dec.e.alu = ALU_NOT;
                dec.w     = W_ALU;
                dec.legal = 1'b1;
            end
            OP_BR: begin
                dec.e.pcsel1 = PCS1_OFF9;
                dec.e.pcsel2 = PCS2_NPC;
                dec.legal    = 1'b1;
            end
            OP_JMP: begin
                dec.e.pcsel1 = PCS1_ZERO;
                dec.e.pcsel2 = PCS2_VSR1;
                dec.legal    = 1'b1;
            end
            OP_LD: begin
                dec.e.pcsel1 = PCS1_OFF9;
                dec.e.pcsel2 = PCS2_NPC;
                dec.w        = W_MEM;
                dec.legal    = 1'b1;
            end
            OP_LDR: begin
                dec.e.pcsel1 = PCS1_OFF6;
                dec.e.pcsel2 = PCS2_VSR1;
                dec.w        = W_MEM;
                dec.legal    = 1'b1;
            end
            OP_LDI: begin
                dec.e.pcsel1 = PCS1_OFF9;
                dec.e.pcsel2 = PCS2_NPC;
                dec.w        = W_MEM;
                dec.mem      = 1'b1;
                dec.legal    = 1'b1;
            end
            OP_LEA: begin
                dec.e.pcsel1 = PCS1_OFF9;
                dec.e.pcsel2 = PCS2_NPC;
                dec.w        = W_PC;
                dec.legal    = 1'b1;
            end
            OP_ST: begin
                dec.e.pcsel1 = PCS1_OFF9;
                dec.e.pcsel2 = PCS2_NPC;
                dec.legal    = 1'b1;
            end
            OP_STR: begin
                dec.e.pcsel1 = PCS1_OFF6;
                dec.e.pcsel2 = PCS2_VSR1;
                dec.legal    = 1'b1;
            end
            OP_STI: begin
                dec.e.pcsel1 = PCS1_OFF9;
                dec.e.pcsel2 = PCS2_NPC;
                dec.mem      = 1'b1;
                dec.legal    = 1'b1;
            end
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers IR, npc and execute/mem/wb controls.
// Optional macro DECODE_ILLEGAL_FLAG_EN adds the illegal_op output.
module lc3_decode
    import lc3_decode_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = DEF_NOP_INSTR,
    parameter logic [15:0] RESET_NPC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic        flush,
    input  logic [15:0] dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control,
    output logic        Mem_Control,
`ifdef DECODE_ILLEGAL_FLAG_EN
    output logic        illegal_op,
`endif
    output logic        valid_out
);

    dec_t dec;

    lc3_decode_ctl u_ctl (
        .opcode   (dout[15:12]),
        .imm_flag (dout[5]),
        .dec      (dec)
    );

    // Pipeline register: flush beats load; illegal loads become NOP.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            IR          <= NOP_INSTR;
            npc_out     <= RESET_NPC;
            E_Control   <= '0;
            W_Control   <= '0;
            Mem_Control <= 1'b0;
            valid_out   <= 1'b0;
        end else if (flush) begin
            IR          <= NOP_INSTR;
            npc_out     <= npc_in;
            E_Control   <= '0;
            W_Control   <= '0;
            Mem_Control <= 1'b0;
            valid_out   <= 1'b0;
        end else if (enable_decode) begin
            npc_out <= npc_in;
            if (dec.legal) begin
                IR          <= dout;
                E_Control   <= dec.e;
                W_Control   <= dec.w;
                Mem_Control <= dec.mem;
                valid_out   <= 1'b1;
            end else begin
                IR          <= NOP_INSTR;
                E_Control   <= '0;
                W_Control   <= '0;
                Mem_Control <= 1'b0;
                valid_out   <= 1'b0;
            end
        end
    end

`ifdef DECODE_ILLEGAL_FLAG_EN
    // Marks loads that hit an unlisted opcode; held on stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            illegal_op <= 1'b0;
        end else if (flush) begin
            illegal_op <= 1'b0;
        end else if (enable_decode) begin
            illegal_op <= ~dec.legal;
        end
    end
`endif

endmodule

// File: tb/tb_lc3_decode.sv
// Scoreboard bench for lc3_decode.
// Build with DECODE_ILLEGAL_FLAG_EN to also check illegal_op.
module tb_lc3_decode;

    logic        clock;
    logic        reset;
    logic        enable_decode;
    logic        flush;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        valid_out;
`ifdef DECODE_ILLEGAL_FLAG_EN
    logic        illegal_op;
`endif

    typedef struct {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        v;
        logic        il;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    lc3_decode dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .flush         (flush),
        .dout          (dout),
        .npc_in        (npc_in),
        .IR            (IR),
        .npc_out       (npc_out),
        .E_Control     (E_Control),
        .W_Control     (W_Control),
        .Mem_Control   (Mem_Control),
`ifdef DECODE_ILLEGAL_FLAG_EN
        .illegal_op    (illegal_op),
`endif
        .valid_out     (valid_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endtask

    task automatic chk_all(input string tag, input exp_t x);
        chk({tag, ".IR"}, IR, x.ir);
        chk({tag, ".npc"}, npc_out, x.npc);
        chk({tag, ".E"}, {10'd0, E_Control}, {10'd0, x.e});
        chk({tag, ".W"}, {14'd0, W_Control}, {14'd0, x.w});
        chk({tag, ".Mem"}, {15'd0, Mem_Control}, {15'd0, x.m});
        chk({tag, ".valid"}, {15'd0, valid_out}, {15'd0, x.v});
`ifdef DECODE_ILLEGAL_FLAG_EN
        chk({tag, ".illegal"}, {15'd0, illegal_op}, {15'd0, x.il});
`endif
    endtask

    // Monitor: compare DUT outputs with queued expectations.
    int vec_no = 0;
    always @(negedge clock) begin
        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk_all($sformatf("vec%0d", vec_no), x);
            vec_no++;
        end
    end

    // One stimulus cycle: drive at negedge, queue expectation after posedge.
    task automatic vec(input logic en, input logic fl,
                       input logic [15:0] d, input logic [15:0] n,
                       input logic [15:0] eir, input logic [15:0] enpc,
                       input logic [5:0] ee, input logic [1:0] ew,
                       input logic em, input logic ev, input logic eil);
        exp_t x;
        @(negedge clock);
        enable_decode = en;
        flush         = fl;
        dout          = d;
        npc_in        = n;
        @(posedge clock);
        #1;
        x.ir = eir; x.npc = enpc; x.e = ee; x.w = ew;
        x.m = em; x.v = ev; x.il = eil;
        sb.push_back(x);
    endtask

    exp_t rst_x;

    initial begin
        rst_x.ir = 16'h0000; rst_x.npc = 16'h0000; rst_x.e = 6'd0;
        rst_x.w = 2'd0; rst_x.m = 1'b0; rst_x.v = 1'b0; rst_x.il = 1'b0;

        reset = 1'b1; enable_decode = 1'b0; flush = 1'b0;
        dout = 16'h0000; npc_in = 16'h0000;
        #1;
        chk_all("reset0", rst_x);
        @(negedge clock);
        reset = 1'b0;

        //  en fl dout     npc      IR       npc      E          W     M  V  il
        vec(1, 0, 16'h1283, 16'h3001, 16'h1283, 16'h3001, 6'b000001, 2'b00, 0, 1, 0);
        vec(1, 0, 16'h1223, 16'h3002, 16'h1223, 16'h3002, 6'b000000, 2'b00, 0, 1, 0);
        vec(1, 0, 16'h5283, 16'h3003, 16'h5283, 16'h3003, 6'b010001, 2'b00, 0, 1, 0);
        vec(1, 0, 16'h5263, 16'h3004, 16'h5263, 16'h3004, 6'b010000, 2'b00, 0, 1, 0);
        vec(1, 0, 16'h967F, 16'h3005, 16'h967F, 16'h3005, 6'b100000, 2'b00, 0, 1, 0);
        vec(1, 0, 16'h0E05, 16'h3006, 16'h0E05, 16'h3006, 6'b000110, 2'b00, 0, 1, 0);
        vec(1, 0, 16'hC1C0, 16'h3007, 16'hC1C0, 16'h3007, 6'b001100, 2'b00, 0, 1, 0);
        vec(1, 0, 16'h2405, 16'h3008, 16'h2405, 16'h3008, 6'b000110, 2'b01, 0, 1, 0);
        vec(1, 0, 16'h6283, 16'h3009, 16'h6283, 16'h3009, 6'b001000, 2'b01, 0, 1, 0);
        vec(1, 0, 16'hA405, 16'h300A, 16'hA405, 16'h300A, 6'b000110, 2'b01, 1, 1, 0);
        vec(0, 0, 16'h1283, 16'h300B, 16'hA405, 16'h300A, 6'b000110, 2'b01, 1, 1, 0);
        vec(0, 0, 16'h967F, 16'h300C, 16'hA405, 16'h300A, 6'b000110, 2'b01, 1, 1, 0);
        vec(0, 0, 16'hF025, 16'h300D, 16'hA405, 16'h300A, 6'b000110, 2'b01, 1, 1, 0);
        vec(1, 1, 16'h6283, 16'h4000, 16'h0000, 16'h4000, 6'b000000, 2'b00, 0, 0, 0);
        vec(1, 0, 16'hE1FF, 16'h4001, 16'hE1FF, 16'h4001, 6'b000110, 2'b10, 0, 1, 0);
        vec(1, 0, 16'h3405, 16'h4002, 16'h3405, 16'h4002, 6'b000110, 2'b00, 0, 1, 0);
        vec(1, 0, 16'h7283, 16'h4003, 16'h7283, 16'h4003, 6'b001000, 2'b00, 0, 1, 0);
        vec(1, 0, 16'hB405, 16'h4004, 16'hB405, 16'h4004, 6'b000110, 2'b00, 1, 1, 0);
        vec(1, 0, 16'hF025, 16'h4005, 16'h0000, 16'h4005, 6'b000000, 2'b00, 0, 0, 1);
        vec(0, 0, 16'h1283, 16'h4006, 16'h0000, 16'h4005, 6'b000000, 2'b00, 0, 0, 1);
        vec(1, 0, 16'h4000, 16'h4007, 16'h0000, 16'h4007, 6'b000000, 2'b00, 0, 0, 1);
        vec(1, 0, 16'h8000, 16'h4008, 16'h0000, 16'h4008, 6'b000000, 2'b00, 0, 0, 1);
        vec(1, 0, 16'hD000, 16'h4009, 16'h0000, 16'h4009, 6'b000000, 2'b00, 0, 0, 1);
        vec(1, 0, 16'h1283, 16'h400A, 16'h1283, 16'h400A, 6'b000001, 2'b00, 0, 1, 0);
        vec(0, 1, 16'h1283, 16'h400B, 16'h0000, 16'h400B, 6'b000000, 2'b00, 0, 0, 0);
        vec(1, 0, 16'hA405, 16'h400C, 16'hA405, 16'h400C, 6'b000110, 2'b01, 1, 1, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, required 0", sb.size());

        // Asynchronous reset mid-run, then held across a flush edge.
        #1;
        reset = 1'b1;
        #1;
        chk_all("reset_async", rst_x);
        flush = 1'b1; enable_decode = 1'b0;
        npc_in = 16'h5555; dout = 16'h1283;
        @(posedge clock);
        #1;
        chk_all("reset_flush", rst_x);
        @(negedge clock);
        reset = 1'b0; flush = 1'b0; enable_decode = 1'b0;
        @(posedge clock);
        #1;
        chk_all("reset_hold", rst_x);

        vec(1, 0, 16'h5283, 16'h6000, 16'h5283, 16'h6000, 6'b010001, 2'b00, 0, 1, 0);
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain2: got %0d pending, required 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
